// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencer for the 8-bit instruction memory / instruction-register path.
//   Load mode writes the program into memory one byte per strobe; run mode walks a
//   program counter through memory and hands each fetched instruction to the decoder
//   over a valid/ready handshake. Supports branch redirects, a halt opcode and an
//   external halt request.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, halt_req                  run control
//   load_valid/addr/data, load_ready loader write port
//   mem_addr/wdata/we/active         memory request side
//   mem_rdata, mem_rvalid            memory read response
//   instr_out/valid, instr_ready     decoder handshake
//   br_taken, br_target              redirect, sampled with instruction accept
//   pc, busy, halted                 status
module fetch_ctrl #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [DATA_W-1:0] HALT_OP  = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt_req,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_active,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [DATA_W-1:0] instr_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FETCH,
      S_ISSUE,
      S_HALT
   } state_e;

   state_e            state_q, state_d;
   state_e            ret_q, ret_d;        // state LOAD returns to (IDLE or HALT)
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              ivalid_q, ivalid_d;
   logic              hpend_q, hpend_d;
   logic              we_q, active_q, busy_q, halted_q, lready_q;

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      instr_d  = instr_q;
      ivalid_d = ivalid_q;
      hpend_d  = hpend_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (load_valid) begin
               state_d = S_LOAD;
               ret_d   = state_q;
               addr_d  = load_addr;
               wdata_d = load_data;
            end else if (start) begin
               state_d = S_FETCH;
               pc_d    = RESET_PC;
               addr_d  = RESET_PC;
               hpend_d = 1'b0;
            end
         end
         S_LOAD: state_d = ret_q;
         S_FETCH: begin
            if (halt_req) hpend_d = 1'b1;
            if (mem_rvalid) begin
               instr_d = mem_rdata;
               if (mem_rdata == HALT_OP) begin
                  state_d = S_HALT;
               end else begin
                  state_d  = S_ISSUE;
                  ivalid_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (halt_req) hpend_d = 1'b1;
            if (instr_ready) begin
               ivalid_d = 1'b0;
               pc_d     = br_taken ? br_target : pc_q + 1'b1;
               if (hpend_q || halt_req) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_FETCH;
                  addr_d  = pc_d;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Status/strobe outputs are flopped decodes of the next state, so they line up
   // with state_q without any combinational path to the pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ret_q    <= S_IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= '0;
         wdata_q  <= '0;
         instr_q  <= '0;
         ivalid_q <= 1'b0;
         hpend_q  <= 1'b0;
         we_q     <= 1'b0;
         active_q <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         lready_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         instr_q  <= instr_d;
         ivalid_q <= ivalid_d;
         hpend_q  <= hpend_d;
         we_q     <= (state_d == S_LOAD);
         active_q <= (state_d == S_FETCH);
         busy_q   <= (state_d == S_FETCH) || (state_d == S_ISSUE);
         halted_q <= (state_d == S_HALT) || ((state_d == S_LOAD) && (ret_d == S_HALT));
         lready_q <= (state_d == S_IDLE) || (state_d == S_HALT);
      end
   end

   assign load_ready  = lready_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_we      = we_q;
   assign mem_active  = active_q;
   assign instr_out   = instr_q;
   assign instr_valid = ivalid_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, halt_req, load_valid, load_ready;
   logic [7:0] load_addr, load_data;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, mem_active, mem_rvalid;
   logic [7:0] instr_out;
   logic       instr_valid, instr_ready, br_taken;
   logic [7:0] br_target, pc;
   logic       busy, halted;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] imem [256];
   int         mem_wait;
   int         mem_cnt;
   logic [7:0] issued [$];

   always #5 clk = ~clk;

   fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00), .HALT_OP(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .load_ready(load_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_active(mem_active), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .instr_out(instr_out), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .br_taken(br_taken), .br_target(br_target),
      .pc(pc), .busy(busy), .halted(halted)
   );

   // memory model: write on strobe, answer reads after mem_wait idle cycles
   always @(posedge clk) if (mem_we) imem[mem_addr] <= mem_wdata;

   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      if (mem_active) begin
         if (mem_cnt >= mem_wait) begin
            mem_rvalid = 1'b1;
            mem_rdata  = imem[mem_addr];
            mem_cnt    = 0;
         end else begin
            mem_cnt++;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   always @(posedge clk) if (rst_n && instr_valid && instr_ready) issued.push_back(instr_out);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0; start = 0; halt_req = 0; load_valid = 0; load_addr = 0; load_data = 0;
      instr_ready = 0; br_taken = 0; br_target = 0;
      mem_rvalid = 0; mem_rdata = 0; mem_wait = 0; mem_cnt = 0;
      for (int i = 0; i < 256; i++) imem[i] = 8'h5A;
      imem[2] = 8'hFF;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("rst_lready", load_ready, 1);
      check("rst_pc", pc, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_we", mem_we, 0);
      check("rst_active", mem_active, 0);
      check("rst_ivalid", instr_valid, 0);

      // two loads back to back: 06@01 then 02@00
      load_valid = 1; load_addr = 8'h01; load_data = 8'h06;
      tick();
      check("ld1_we", mem_we, 1);
      check("ld1_addr", mem_addr, 8'h01);
      check("ld1_data", mem_wdata, 8'h06);
      check("ld1_lready", load_ready, 0);
      load_addr = 8'h00; load_data = 8'h02;
      tick();
      check("ld1_we_end", mem_we, 0);
      check("ld1_lready_end", load_ready, 1);
      tick();
      check("ld2_we", mem_we, 1);
      check("ld2_addr", mem_addr, 8'h00);
      check("ld2_data", mem_wdata, 8'h02);
      check("ld2_lready", load_ready, 0);
      load_valid = 0;
      tick();
      check("ld2_we_end", mem_we, 0);
      check("ld_mem1", imem[1], 8'h06);
      check("ld_mem0", imem[0], 8'h02);

      // run: 02, 06 issued, FF halts
      issued.delete();
      instr_ready = 1; start = 1;
      tick();
      start = 0;
      check("r1_busy", busy, 1);
      check("r1_active", mem_active, 1);
      check("r1_addr", mem_addr, 8'h00);
      tick();
      check("r1_ivalid", instr_valid, 1);
      check("r1_iout", instr_out, 8'h02);
      check("r1_active_off", mem_active, 0);
      n = 0;
      while (!halted && n < 50) begin tick(); n++; end
      check("r1_tmo", n < 50, 1);
      check("r1_pc", pc, 8'h02);
      check("r1_ivalid_h", instr_valid, 0);
      check("r1_busy_h", busy, 0);
      check("r1_count", issued.size(), 2);
      if (issued.size() == 2) begin
         check("r1_i0", issued[0], 8'h02);
         check("r1_i1", issued[1], 8'h06);
      end

      // stalled decoder; a load attempted while busy must be ignored
      issued.delete();
      instr_ready = 0; start = 1;
      tick();
      start = 0;
      tick();
      check("st_ivalid", instr_valid, 1);
      check("st_iout", instr_out, 8'h02);
      load_valid = 1; load_addr = 8'h80; load_data = 8'h99;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("st_hold_v", instr_valid, 1);
         check("st_hold_o", instr_out, 8'h02);
         check("st_hold_pc", pc, 8'h00);
         check("st_lready", load_ready, 0);
         check("st_we", mem_we, 0);
      end
      load_valid = 0; instr_ready = 1;
      tick();
      check("st_acc_v", instr_valid, 0);
      check("st_acc_pc", pc, 8'h01);
      check("st_acc_act", mem_active, 1);
      n = 0;
      while (!halted && n < 50) begin tick(); n++; end
      check("st_tmo", n < 50, 1);
      check("st_pc", pc, 8'h02);
      check("st_count", issued.size(), 2);
      check("st_noload", imem[8'h80], 8'h5A);

      // load from HALT keeps halted and returns to HALT
      load_valid = 1; load_addr = 8'h40; load_data = 8'h77;
      tick();
      check("hl_we", mem_we, 1);
      check("hl_halted", halted, 1);
      check("hl_lready", load_ready, 0);
      load_valid = 0;
      tick();
      check("hl_back_halted", halted, 1);
      check("hl_back_lready", load_ready, 1);
      check("hl_back_busy", busy, 0);

      // branch at pc 05 to F0, then wrap FF -> 00
      imem[2] = 8'h07; imem[3] = 8'h33;
      start = 1;
      tick();
      start = 0;
      n = 0;
      while (!(instr_valid && pc == 8'h05) && n < 100) begin tick(); n++; end
      check("br_tmo", n < 100, 1);
      br_taken = 1; br_target = 8'hF0;
      tick();
      br_taken = 0; br_target = 8'h00;
      check("br_pc", pc, 8'hF0);
      check("br_addr", mem_addr, 8'hF0);
      check("br_active", mem_active, 1);
      n = 0;
      while (!(instr_valid && pc == 8'hFF) && n < 100) begin tick(); n++; end
      check("wr_tmo", n < 100, 1);
      tick();
      check("wr_pc", pc, 8'h00);
      check("wr_addr", mem_addr, 8'h00);

      // halt request during FETCH of pc 03
      mem_wait = 2;
      n = 0;
      while (!(mem_active && pc == 8'h03) && n < 100) begin tick(); n++; end
      check("hq_tmo", n < 100, 1);
      halt_req = 1;
      tick();
      halt_req = 0;
      n = 0;
      while (!instr_valid && n < 20) begin tick(); n++; end
      check("hq_tmo2", n < 20, 1);
      check("hq_iout", instr_out, 8'h33);
      check("hq_pc3", pc, 8'h03);
      tick();
      check("hq_halted", halted, 1);
      check("hq_pc4", pc, 8'h04);
      check("hq_busy", busy, 0);
      check("hq_ivalid", instr_valid, 0);

      // restart from 00, then reset mid-FETCH of pc 01
      start = 1;
      tick();
      start = 0;
      check("rs_pc", pc, 8'h00);
      check("rs_addr", mem_addr, 8'h00);
      check("rs_halted", halted, 0);
      check("rs_busy", busy, 1);
      n = 0;
      while (!(mem_active && pc == 8'h01) && n < 50) begin tick(); n++; end
      check("rs_tmo", n < 50, 1);
      mem_wait = 10;
      tick();
      check("rm_active", mem_active, 1);
      rst_n = 0;
      tick();
      check("rm_active0", mem_active, 0);
      check("rm_pc", pc, 8'h00);
      check("rm_lready", load_ready, 1);
      check("rm_busy", busy, 0);
      check("rm_ivalid", instr_valid, 0);
      rst_n = 1;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
